// File: rtl/arbitro_memoria_pkg.sv
// Shared encodings for the memory arbiter: sequencer states and access owner.
package arbitro_memoria_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DT   = 2'd2
  } owner_t;

endpackage

// File: rtl/arbitro_memoria_if.sv
// Bundle of requester handshakes and memoram pins seen by the arbiter.
// The slave side is the arbiter; the master side is the requesters plus the memory.
interface arbitro_memoria_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dt_req;
  logic              dt_we;
  logic [ADDR_W-1:0] dt_addr;
  logic [DATA_W-1:0] dt_wdata;
  logic              dt_ack;
  logic              dt_rvalid;
  logic [DATA_W-1:0] dt_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  logic              busy;

  modport slave (
    input  if_req, if_addr, dt_req, dt_we, dt_addr, dt_wdata, mem_q,
    output if_ack, if_rvalid, if_rdata, dt_ack, dt_rvalid, dt_rdata,
    output mem_address, mem_data, mem_wren, busy
  );

  modport master (
    output if_req, if_addr, dt_req, dt_we, dt_addr, dt_wdata, mem_q,
    input  if_ack, if_rvalid, if_rdata, dt_ack, dt_rvalid, dt_rdata,
    input  mem_address, mem_data, mem_wren, busy
  );

endinterface

// File: rtl/arbitro_memoria_seletor_dono.sv
// Owner pick for the next grant: data first, unless fetch has waited through
// MAX_DATA_STREAK consecutive data grants.
module seletor_dono
  import arbitro_memoria_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req,
  input  logic   dt_req,
  input  logic   idle,
  input  logic   grant,
  output owner_t owner
);

  localparam int            SW         = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] streak;
  logic          force_if;

  assign force_if = if_req && (streak == STREAK_MAX);

  always_comb begin
    // NOTE: default assigned first so every path drives owner and no latch is inferred.
    owner = OWN_NONE;
    if (dt_req && !force_if) begin
      owner = OWN_DT;
    end else if (if_req) begin
      owner = OWN_IF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (idle) begin
      // Only data grants that actually starve a pending fetch count.
      if (!if_req || (grant && owner == OWN_IF)) begin
        streak <= '0;
      end else if (grant && owner == OWN_DT && streak != STREAK_MAX) begin
        streak <= streak + 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_memoria.sv
// Single-port arbiter/sequencer for the shared instruction/data memoram.
// Hides the registered read latency behind req/ack/rvalid handshakes (READ_LAT >= 2).
module arbitro_memoria
  import arbitro_memoria_pkg::*;
#(
  parameter int ADDR_W          = 4,
  parameter int DATA_W          = 16,
  parameter int READ_LAT        = 2,
  parameter int MAX_DATA_STREAK = 2
) (
  input logic              clk,
  input logic              rst,
  arbitro_memoria_if.slave bus
);

  localparam int            LW      = $clog2(READ_LAT + 1);
  localparam logic [LW-1:0] LAT_END = LW'(READ_LAT);

  logic [1:0]    state;
  owner_t        owner_q;
  owner_t        pick;
  logic          idle;
  logic          grant;
  logic [LW-1:0] lat_cnt;
  logic [LW-1:0] lat_nxt;

  assign idle    = (state == ST_IDLE);
  assign grant   = idle && (bus.if_req || bus.dt_req);
  assign lat_nxt = lat_cnt + 1'b1;

  seletor_dono #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_seletor_dono (
    .clk   (clk),
    .rst   (rst),
    .if_req(bus.if_req),
    .dt_req(bus.dt_req),
    .idle  (idle),
    .grant (grant),
    .owner (pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      owner_q         <= OWN_NONE;
      lat_cnt         <= '0;
      bus.if_ack      <= 1'b0;
      bus.dt_ack      <= 1'b0;
      bus.if_rvalid   <= 1'b0;
      bus.dt_rvalid   <= 1'b0;
      bus.if_rdata    <= '0;
      bus.dt_rdata    <= '0;
      bus.mem_address <= '0;
      bus.mem_data    <= '0;
      bus.mem_wren    <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
      bus.if_ack    <= 1'b0;
      bus.dt_ack    <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.dt_rvalid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner_q  <= pick;
            state    <= ST_ACCESS;
            bus.busy <= 1'b1;
            if (pick == OWN_DT) begin
              bus.mem_address <= bus.dt_addr;
              bus.mem_data    <= bus.dt_wdata;
              bus.mem_wren    <= bus.dt_we;
              bus.dt_ack      <= 1'b1;
            end else begin
              bus.mem_address <= bus.if_addr;
              bus.mem_data    <= '0;
              bus.mem_wren    <= 1'b0;
              bus.if_ack      <= 1'b1;
            end
          end
        end

        ST_ACCESS: begin
          // The memory samples address/data/wren on this edge.
          if (bus.mem_wren) begin
            bus.mem_wren <= 1'b0;
            owner_q      <= OWN_NONE;
            state        <= ST_IDLE;
            bus.busy     <= 1'b0;
          end else begin
            lat_cnt <= LW'(1);
            state   <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          lat_cnt <= lat_nxt;
          if (lat_nxt == LAT_END) begin
            state <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (owner_q == OWN_DT) begin
            bus.dt_rdata  <= bus.mem_q;
            bus.dt_rvalid <= 1'b1;
          end else begin
            bus.if_rdata  <= bus.mem_q;
            bus.if_rvalid <= 1'b1;
          end
          owner_q  <= OWN_NONE;
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/arbitro_memoria.md
Name: arbitro_memoria

Overview:
- Single-port arbiter and sequencer for the shared instruction/data memoram. Two requesters compete for it: the instruction-fetch queue (read-only) and the load/store path (read/write).
- Owns the memory's address, data and write-enable pins.
- Hides the memory's registered read latency behind a request/ack/rvalid handshake.
- Fixed priority favours data, with a streak limit that guarantees fetch progress.

Parameters:
- ADDR_W, 4, memory address width (16 words).
- DATA_W, 16, word width.
- READ_LAT, 2, clock edges from the memory sampling the address to q being stable (address register plus output register).
- MAX_DATA_STREAK, 2, consecutive data grants allowed while fetch is pending before fetch is forced.

Ports:
- Clock  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- if_req  in  1  fetch read request; level, held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetch read data.
- dt_req  in  1  data request; level, held until dt_ack.
- dt_we  in  1  1 = write, 0 = read.
- dt_addr  in  ADDR_W  data address.
- dt_wdata  in  DATA_W  write data.
- dt_ack  out  1  one-cycle pulse: data request accepted.
- dt_rvalid  out  1  one-cycle pulse: dt_rdata valid (reads only).
- dt_rdata  out  DATA_W  data read data.
- mem_address  out  ADDR_W  to memoram address.
- mem_data  out  DATA_W  to memoram data.
- mem_wren  out  1  to memoram wren.
- mem_q  in  DATA_W  from memoram q.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: all outputs 0, including rdata registers and mem_*. State IDLE, owner none, streak 0.
- Reset asserted mid-transaction aborts it. No rvalid is produced for the aborted read. A write whose wren was already high is not guaranteed.
- All outputs are registered.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE, edge E0 with any req sampled:
  - Select owner:
    - dt_req && !(if_req && streak==MAX_DATA_STREAK) selects data.
    - Otherwise if_req selects fetch.
  - Register mem_address, mem_data, and mem_wren (dt_we for data, 0 for fetch).
  - Pulse the owner's ack for the cycle after E0.
  - Go to ACCESS.
  - The requester may drop req or change its inputs after seeing ack; the arbiter has captured them.
- ACCESS, edge E1: the memory samples the address.
  - Write: mem_wren<=0, go to IDLE. No rvalid is produced.
  - Read: go to WAIT with latency counter = 1.
- WAIT: the counter increments each edge. When it reaches READ_LAT, go to RESP. For READ_LAT=2, that is edge E2.
- RESP, edge E3 (E1+READ_LAT):
  - Capture mem_q into the owner's rdata.
  - Pulse the owner's rvalid for one cycle.
  - Go to IDLE.
- Read latency: req sampled at E0 gives rvalid high during E3–E4.
- Issue rate: next grant no earlier than E4. Writes issue every 2 cycles.
- The non-owner's rdata holds its previous value. Only one rvalid is ever high.
- Streak counter:
  - Increments on a data grant made while if_req=1.
  - Clears on any fetch grant, or on any edge in IDLE where if_req=0.
  - Saturates at MAX_DATA_STREAK.
- Simultaneous requests with streak<MAX: data wins and fetch waits, ack stays 0.
- A request arriving while busy is ignored until IDLE. Its req must remain high.
- Address wrap is the requester's concern. The arbiter passes ADDR_W bits unchanged.

Decomposition:
- Shared package: state encoding (IDLE/ACCESS/WAIT/RESP) and owner encoding (OWN_NONE/OWN_IF/OWN_DT).
- Width parameters stay module parameters.
- One natural sub-module, seletor_dono: combinational owner pick plus the streak counter register. It takes Clock/Reset, if_req, dt_req and a grant strobe, and outputs the owner.

Test Plan:
- Reset mid-read: if_req=1 at E0, Reset pulsed during WAIT -> no if_rvalid, all outputs 0, busy=0 asynchronously.
- Single fetch: memory preloaded word[3]=16'hA5C3, if_req with if_addr=3 -> if_ack one cycle after E0, if_rvalid with if_rdata=16'hA5C3 exactly 3 edges after acceptance.
- Data write then read: dt_we=1, addr=9, wdata=16'h1234 -> mem_wren high one cycle, no rvalid. Then a read of addr 9 -> dt_rdata=16'h1234.
- Contention: if_req and dt_req held high, both reads -> grant order DT, DT, IF, DT, DT, IF (MAX_DATA_STREAK=2). No overlapping rvalids.
- Back-to-back fetch: if_req held continuously with addr incrementing 0..3 -> acks every 4 cycles, rdata in address order, busy low exactly one cycle between reads.
